// File: rtl/nn_pixel_feeder_if.sv
// Raw pixel byte stream into the digit-network feeder (valid/ready).
interface nn_pixel_feeder_if #(
  parameter int PIX_BITS = 8
);
  logic [PIX_BITS-1:0] s_pixel;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_pixel, s_valid, input s_ready);
  modport slave  (input s_pixel, s_valid, output s_ready);
endinterface

// File: rtl/nn_pixel_feeder.sv
// Streams one image of fixed-point pixels into the digit network, then captures predict_num.
// Optional build macro PIXEL_BINARIZE_EN: threshold pixels to 0 / 1.0 instead of linear scaling.
module nn_pixel_feeder #(
  parameter int BITS_INT    = 4,
  parameter int BITS_FRC    = 12,
  parameter int PIX_BITS    = 8,
  parameter int WIDTH       = 784,
  parameter int WAIT_CYCLES = 16,
  parameter int THRESHOLD   = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  nn_pixel_feeder_if.slave             pix,
  output logic [BITS_INT+BITS_FRC-1:0] input_pixel,
  output logic [9:0]                   pixel_counter,
  input  logic [BITS_INT+BITS_FRC-1:0] predict_num,
  output logic                         busy,
  output logic                         result_valid,
  output logic [BITS_INT+BITS_FRC-1:0] result
);
  localparam int DW  = BITS_INT + BITS_FRC;
  localparam int WCW = $clog2(WAIT_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  if (BITS_FRC < PIX_BITS || WIDTH > 1024 || WIDTH < 1 || WAIT_CYCLES < 1 ||
      THRESHOLD < 0 || THRESHOLD > (1 << PIX_BITS)) begin : g_bad_cfg
    $error("nn_pixel_feeder: illegal parameter combination");
  end

  function automatic logic [DW-1:0] conv(input logic [PIX_BITS-1:0] p);
`ifdef PIXEL_BINARIZE_EN
    return ({1'b0, p} >= (PIX_BITS+1)'(THRESHOLD)) ? (DW'(1) << BITS_FRC) : '0;
`else
    return DW'(p) << (BITS_FRC - PIX_BITS);
`endif
  endfunction

  logic [1:0]     state, state_nxt;
  logic [9:0]     idx;
  logic [WCW-1:0] wait_cnt;
  logic           hs, last_hs, cap, go;

  assign pix.s_ready = (state == ST_STREAM);
  assign hs      = pix.s_valid & (state == ST_STREAM);
  assign last_hs = hs & (idx == 10'(WIDTH - 1));
  assign cap     = (state == ST_WAIT) & (wait_cnt == WCW'(WAIT_CYCLES - 1));
  // start is only honoured while parked; STREAM/WAIT never see it
  assign go      = start & ((state == ST_IDLE) | (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (go)      state_nxt = ST_STREAM;
      ST_STREAM: if (last_hs) state_nxt = ST_WAIT;
      ST_WAIT:   if (cap)     state_nxt = ST_DONE;
      ST_DONE:   if (go)      state_nxt = ST_STREAM;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      idx           <= '0;
      wait_cnt      <= '0;
      input_pixel   <= '0;
      pixel_counter <= '0;
      result_valid  <= 1'b0;
      result        <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_STREAM) | (state_nxt == ST_WAIT);
      if (go) begin
        idx          <= '0;
        result_valid <= 1'b0;
      end else if (hs) begin
        idx <= idx + 10'd1;
      end
      if (hs) begin
        input_pixel   <= conv(pix.s_pixel);
        pixel_counter <= idx;
      end
      if (last_hs)
        wait_cnt <= '0;
      else if (state == ST_WAIT)
        wait_cnt <= wait_cnt + WCW'(1);
      if (cap) begin
        result       <= predict_num;
        result_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Randomized directed bench for nn_pixel_feeder against a handshake-counting reference model.
module tb_nn_pixel_feeder;
  localparam int BF = 12, PB = 8, W = 784, WC = 16, DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] predict_num = '0;
  logic [DW-1:0] input_pixel, result;
  logic [9:0]    pixel_counter;
  logic          busy, result_valid;

  nn_pixel_feeder_if #(.PIX_BITS(PB)) pix ();

  nn_pixel_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pix          (pix),
    .input_pixel  (input_pixel),
    .pixel_counter(pixel_counter),
    .predict_num  (predict_num),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_pix = '0;
  logic [DW-1:0] exp_res = '0;
  logic [9:0]    exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start, then feed pixels until stop_at handshakes have been made.
  task automatic stream(input int duty, input bit seq_pix, input bit poke_start, input int stop_at);
    int n = 0;
    int guard = 0;
    logic [PB-1:0] p;
    bit v;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ready_after_start", pix.s_ready, 1);
    check("busy_after_start", busy, 1);
    check("rv_cleared_on_start", result_valid, 0);
    check("result_kept_on_start", result, exp_res);
    while (n < stop_at && guard < 20000) begin
      v = ($urandom_range(99) < duty);
      p = seq_pix ? PB'(n % 256) : PB'($urandom);
      pix.s_valid = v;
      pix.s_pixel = p;
      start = poke_start && (($urandom_range(9) == 0) || n == W - 1);
      tick;
      guard++;
      if (v) begin
        exp_pix = DW'(p) << (BF - PB);
        exp_cnt = 10'(n);
        n++;
      end
      check("pixel_counter", pixel_counter, exp_cnt);
      check("input_pixel", input_pixel, exp_pix);
      if (n < W) check("ready_in_stream", pix.s_ready, 1);
    end
    pix.s_valid = 1'b0;
    start = 1'b0;
    check("stream_pixel_count", n, stop_at);
    if (stop_at == W) begin
      check("ready_falls_after_last", pix.s_ready, 0);
      check("busy_in_wait", busy, 1);
    end
  endtask

  task automatic wait_result(input logic [DW-1:0] pred, input bit poke_start);
    for (int c = 1; c <= WC; c++) begin
      start = poke_start && ($urandom_range(1) == 1 || c == WC);
      tick;
      check("ready_low_wait", pix.s_ready, 0);
      if (c < WC) begin
        check("rv_low_wait", result_valid, 0);
        check("result_old_wait", result, exp_res);
        check("busy_wait", busy, 1);
      end else begin
        check("rv_at_latency", result_valid, 1);
        check("result_capture", result, pred);
        check("busy_done", busy, 0);
      end
    end
    start = 1'b0;
    exp_res = pred;
    tick;
    check("rv_hold_done", result_valid, 1);
    check("result_hold_done", result, exp_res);
    check("ready_done", pix.s_ready, 0);
  endtask

  initial begin
    logic [DW-1:0] pred;
    pix.s_valid = 1'b0;
    pix.s_pixel = '0;
    repeat (3) tick;
    check("rst_ready", pix.s_ready, 0);
    check("rst_input_pixel", input_pixel, 0);
    check("rst_pixel_counter", pixel_counter, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", result, 0);
    reset = 1'b1;
    pix.s_valid = 1'b1;
    repeat (3) tick;
    pix.s_valid = 1'b0;
    check("idle_ready", pix.s_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_counter", pixel_counter, 0);

    // continuous ramp image
    predict_num = 16'h3000;
    stream(100, 1'b1, 1'b0, W);
    wait_result(16'h3000, 1'b0);

    // restart from DONE with backpressure and ignored start pulses
    pred = DW'($urandom);
    predict_num = pred;
    stream(30, 1'b0, 1'b1, W);
    wait_result(pred, 1'b1);

    // reset in the middle of an image
    stream(70, 1'b0, 1'b0, 400);
    reset = 1'b0;
    #1;
    check("midrst_ready", pix.s_ready, 0);
    check("midrst_counter", pixel_counter, 0);
    check("midrst_pixel", input_pixel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    check("midrst_result", result, 0);
    exp_pix = '0;
    exp_cnt = '0;
    exp_res = '0;
    tick;
    reset = 1'b1;
    tick;
    check("post_rst_ready", pix.s_ready, 0);

    // fresh image after the reset streams from index 0
    pred = DW'($urandom);
    predict_num = pred;
    stream(100, 1'b0, 1'b0, W);
    wait_result(pred, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
